e203_icb_arb2: RTL

- Two-master to one-slave ICB arbiter/scheduler for the core's shared memory ICB port (mem_icb_cmd/rsp).
- Master 0 is the instruction-fetch path; master 1 is the load/store path.
- Selects which master drives the slave command channel, holds grant across stalls and locked sequences, and records the master ID of every accepted command so in-order slave responses route back to the correct master.

---
 rtl/e203_icb_arb2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/e203_icb_arb2.sv
// Two-master to one-slave ICB arbiter for the shared memory port.
// Tracks the owner of each outstanding command so responses route back in order.
module e203_icb_arb2 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2,
  parameter int ARBT_RR    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic                            m0_icb_cmd_valid,
  output logic                            m0_icb_cmd_ready,
  input  logic [AW-1:0]                   m0_icb_cmd_addr,
  input  logic                            m0_icb_cmd_read,
  input  logic [DW-1:0]                   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0]                 m0_icb_cmd_wmask,
  input  logic [1:0]                      m0_icb_cmd_size,
  input  logic                            m0_icb_cmd_lock,
  output logic                            m0_icb_rsp_valid,
  input  logic                            m0_icb_rsp_ready,
  output logic [DW-1:0]                   m0_icb_rsp_rdata,
  output logic                            m0_icb_rsp_err,

  input  logic                            m1_icb_cmd_valid,
  output logic                            m1_icb_cmd_ready,
  input  logic [AW-1:0]                   m1_icb_cmd_addr,
  input  logic                            m1_icb_cmd_read,
  input  logic [DW-1:0]                   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0]                 m1_icb_cmd_wmask,
  input  logic [1:0]                      m1_icb_cmd_size,
  input  logic                            m1_icb_cmd_lock,
  output logic                            m1_icb_rsp_valid,
  input  logic                            m1_icb_rsp_ready,
  output logic [DW-1:0]                   m1_icb_rsp_rdata,
  output logic                            m1_icb_rsp_err,

  output logic                            s_icb_cmd_valid,
  input  logic                            s_icb_cmd_ready,
  output logic [AW-1:0]                   s_icb_cmd_addr,
  output logic                            s_icb_cmd_read,
  output logic [DW-1:0]                   s_icb_cmd_wdata,
  output logic [DW/8-1:0]                 s_icb_cmd_wmask,
  output logic [1:0]                      s_icb_cmd_size,
  output logic                            s_icb_cmd_lock,
  input  logic                            s_icb_rsp_valid,
  output logic                            s_icb_rsp_ready,
  input  logic [DW-1:0]                   s_icb_rsp_rdata,
  input  logic                            s_icb_rsp_err,

  output logic [$clog2(OUTS_DEPTH+1)-1:0] arb_outs_cnt
);

  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  logic                  rr_last;
  logic                  hold_vld;
  logic                  hold_id;
  logic                  lock_vld;
  logic                  lock_id;
  logic                  grant;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cmd_hs;
  logic                  rsp_hs;
  logic                  head;
  logic [OUTS_DEPTH-1:0] id_mem;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;

  always_comb begin
    grant = 1'b0;
    priority case (1'b1)
      lock_vld: grant = lock_id;
      hold_vld: grant = hold_id;
      m0_icb_cmd_valid & m1_icb_cmd_valid:
        grant = (ARBT_RR != 0) ? ~rr_last : 1'b0;
      m1_icb_cmd_valid: grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign fifo_full  = (arb_outs_cnt == CW'(OUTS_DEPTH));
  assign fifo_empty = (arb_outs_cnt == '0);

  assign s_icb_cmd_valid = (grant ? m1_icb_cmd_valid : m0_icb_cmd_valid)
                           & ~fifo_full;
  assign s_icb_cmd_addr  = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read  = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign s_icb_cmd_size  = grant ? m1_icb_cmd_size  : m0_icb_cmd_size;
  assign s_icb_cmd_lock  = grant ? m1_icb_cmd_lock  : m0_icb_cmd_lock;

  assign m0_icb_cmd_ready = ~grant & s_icb_cmd_ready & ~fifo_full;
  assign m1_icb_cmd_ready =  grant & s_icb_cmd_ready & ~fifo_full;

  assign cmd_hs = s_icb_cmd_valid & s_icb_cmd_ready;
  assign rsp_hs = s_icb_rsp_valid & s_icb_rsp_ready;

  // head is only meaningful while the FIFO holds entries
  assign head = id_mem[rptr];

  assign m0_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & ~head;
  assign m1_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty &  head;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;
  assign s_icb_rsp_ready  = ~fifo_empty
                            & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last  <= 1'b1;
      hold_vld <= 1'b0;
      hold_id  <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else begin
      if (s_icb_cmd_valid & ~s_icb_cmd_ready) begin
        hold_vld <= 1'b1;
        hold_id  <= grant;
      end else if (cmd_hs) begin
        hold_vld <= 1'b0;
      end
      if (cmd_hs & s_icb_cmd_lock) begin
        lock_vld <= 1'b1;
        lock_id  <= grant;
      end else if (cmd_hs & lock_vld & (grant == lock_id)) begin
        lock_vld <= 1'b0;
      end
      if (cmd_hs) begin
        rr_last <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem       <= '0;
      wptr         <= '0;
      rptr         <= '0;
      arb_outs_cnt <= '0;
    end else begin
      if (cmd_hs) begin
        id_mem[wptr] <= grant;
        wptr         <= ptr_inc(wptr);
      end
      if (rsp_hs) begin
        rptr <= ptr_inc(rptr);
      end
      unique case ({cmd_hs, rsp_hs})
        2'b10:   arb_outs_cnt <= arb_outs_cnt + CW'(1);
        2'b01:   arb_outs_cnt <= arb_outs_cnt - CW'(1);
        default: arb_outs_cnt <= arb_outs_cnt;
      endcase
    end
  end

endmodule
